// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC frame packer.
//   packer_state_t   : FSM state encoding
//   HEADER_MAGIC_DEF : default upper half of every header word
//   PAD_WORD         : filler sample used to complete a frame after capture stops
package adc_pkg;
  typedef enum logic [1:0] {IDLE_S, HEADER_S, DATA_S} packer_state_t;

  localparam logic [15:0] HEADER_MAGIC_DEF = 16'hADC5;
  localparam logic [31:0] PAD_WORD         = 32'h0000_0000;
endpackage

// File: rtl/adc_frame_packer_if.sv
// Output stream bundle of the frame packer (ready/valid with tlast).
//   master : driven by the packer (data, valid, last), receives ready
//   slave  : consumer side
interface adc_frame_packer_if;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (output m_tdata, m_tvalid, m_tlast, input m_tready);
  modport slave  (input m_tdata, m_tvalid, m_tlast, output m_tready);
endinterface

// File: rtl/adc_frame_packer_sync_fifo.sv
// Single-clock FIFO with combinational head output.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and data; dropped when full unless popping too
//   pop/dout : read request and current head word
//   count, full, empty : occupancy status
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit tells full (MSBs differ) from empty (equal).
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;

  assign count   = wr_q - rd_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/adc_frame_packer.sv
// Packs ADC sample words into fixed-length frames: header, frame_len samples,
// tlast on the final sample.
//   clk, rst        : clock, synchronous active-high reset
//   enable          : capture enable (also selects pad-fill when the FIFO runs dry)
//   frame_len       : samples per frame, latched at frame start (0 treated as 1)
//   din, din_valid  : sample word and its one-cycle qualifier
//   axis            : output stream (master modport)
//   overflow_cnt    : samples dropped on a full FIFO, saturating
//   frame_cnt       : completed frames, wrapping
//   busy            : frame in progress
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter logic [15:0] HEADER_MAGIC = HEADER_MAGIC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [15:0]                frame_len,
  input  logic [31:0]                din,
  input  logic                       din_valid,
  adc_frame_packer_if.master         axis,
  output logic [15:0]                overflow_cnt,
  output logic [15:0]                frame_cnt,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);

  packer_state_t state_q, state_d;
  logic [15:0]   len_q, len_d, rem_q, rem_d;
  logic [15:0]   frame_q, frame_d, ovf_q, ovf_d;
  logic          pad_hold_q, pad_hold_d;
  logic          push, pop_c, pad_sel;
  logic          tvalid_c, tlast_c;
  logic [31:0]   tdata_c, fifo_dout;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty;

  assign push = din_valid && enable;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rem_d      = rem_q;
    frame_d    = frame_q;
    pad_hold_d = 1'b0;
    pad_sel    = 1'b0;
    pop_c      = 1'b0;
    tvalid_c   = 1'b0;
    tlast_c    = 1'b0;
    tdata_c    = '0;
    case (state_q)
      IDLE_S: begin
        if (!fifo_empty && enable) begin
          len_d   = (frame_len == 16'd0) ? 16'd1 : frame_len;
          state_d = HEADER_S;
        end
      end
      HEADER_S: begin
        tvalid_c = 1'b1;
        tdata_c  = {HEADER_MAGIC, frame_q};
        if (axis.m_tready) begin
          rem_d   = len_q;
          state_d = DATA_S;
        end
      end
      DATA_S: begin
        // Once a pad word is offered it stays offered until taken, so a late
        // re-enable plus push cannot change data under a stalled beat.
        pad_sel  = pad_hold_q || (fifo_empty && !enable);
        tvalid_c = pad_sel || !fifo_empty;
        tdata_c  = pad_sel ? PAD_WORD : fifo_dout;
        tlast_c  = tvalid_c && (rem_q == 16'd1);
        pad_hold_d = pad_sel && !axis.m_tready;
        if (tvalid_c && axis.m_tready) begin
          pop_c = !pad_sel;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            frame_d = frame_q + 16'd1;
            state_d = IDLE_S;
          end
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // A full FIFO only loses the word when no pop frees a slot this cycle.
  assign ovf_d = (push && fifo_full && !pop_c && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE_S;
      len_q      <= '0;
      rem_q      <= '0;
      frame_q    <= '0;
      ovf_q      <= '0;
      pad_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      frame_q    <= frame_d;
      ovf_q      <= ovf_d;
      pad_hold_q <= pad_hold_d;
    end
  end

  assign axis.m_tdata  = tdata_c;
  assign axis.m_tvalid = tvalid_c;
  assign axis.m_tlast  = tlast_c;
  assign overflow_cnt  = ovf_q;
  assign frame_cnt     = frame_q;
  assign busy          = (state_q != IDLE_S);
endmodule
